// File: rtl/mc_control.sv
// mc_control - multi-cycle main control FSM for the non-pipelined MIPS core.
//
// Steps the shared ALU, register file, PC and unified memory through the
// fetch / decode / execute / memory / writeback sequence. It stalls on the
// mem_ready handshake. A wait that runs too long is abandoned with an
// illegal pulse.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//   MEM_TIMEOUT  wait cycles allowed on mem_ready before aborting (0 = never)
//
// Optional feature (macro MC_PERF_CNT_EN):
//   defined   -> instr_count_o counts retired instructions, wrapping
//   undefined -> instr_count_o is tied to zero and no counter flops exist
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode_i          instr[31:26] from the instruction register
//   mem_ready_i       memory access completes this cycle
//   pcwrite_o         unconditional PC load
//   pcwritecond_o     PC load when ALU zero
//   iord_o            memory address select (0 PC, 1 ALUOut)
//   memread_o         memory read strobe
//   memwrite_o        memory write strobe
//   irwrite_o         instruction register load
//   memtoreg_o        register write data select (1 MDR)
//   regdst_o          destination select (1 rd, 0 rt)
//   regwrite_o        register file write enable
//   alusrca_o         ALU A select (0 PC, 1 rs)
//   alusrcb_o         ALU B select (00 rt, 01 4, 10 imm, 11 imm<<2)
//   aluop_o           ALU control (00 add, 01 sub, 10 funct)
//   pcsource_o        PC source (00 ALU, 01 ALUOut, 10 jump target)
//   illegal_o         one-cycle pulse on bad opcode, bad state or timeout
//   state_o           current state encoding, for debug
//   instr_count_o     retired instruction count

module mc_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pcwrite_o,
    output logic             pcwritecond_o,
    output logic             iord_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic             irwrite_o,
    output logic             memtoreg_o,
    output logic             regdst_o,
    output logic             regwrite_o,
    output logic             alusrca_o,
    output logic [1:0]       alusrcb_o,
    output logic [1:0]       aluop_o,
    output logic [1:0]       pcsource_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [5:0]  opcode_q;
    logic        illegal_q, illegal_d;
    logic        waiting;
    logic        timeoutHit;

    // Counts the cycles spent stalled on mem_ready in one of the
    // memory-access states.
    assign waiting = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR))
                     && !mem_ready_i;

    // The timeout fires on the cycle that would be the MEM_TIMEOUT-th
    // consecutive stalled cycle. With MEM_TIMEOUT=N the strobe is therefore
    // held for exactly N cycles before the abort.
    assign timeoutHit = (MEM_TIMEOUT != 0) && waiting
                        && (waitCnt_q == 8'(MEM_TIMEOUT - 1));

    // State register plus the registered illegal pulse, wait counter and the
    // opcode captured in DECODE. The captured opcode lets MEMADR choose
    // between lw and sw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            waitCnt_q <= 8'd0;
            opcode_q  <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            illegal_q <= illegal_d;
            if (state_q == DECODE) begin
                opcode_q <= opcode_i;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready_i) begin
                    state_d = DECODE;
                end else if (timeoutHit) begin
                    illegal_d = 1'b1;
                end
            end
            DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready_i) begin
                    state_d = MEMWB;
                end else if (timeoutHit) begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            MEMWB:  state_d = FETCH;
            MEMWR: begin
                if (mem_ready_i) begin
                    state_d = FETCH;
                end else if (timeoutHit) begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            default: begin
                state_d   = FETCH;
                illegal_d = 1'b1;
            end
        endcase

        // A timeout in FETCH keeps the state but starts a fresh window.
        if ((state_d != state_q) || timeoutHit) begin
            waitCnt_d = 8'd0;
        end else if (waiting && (waitCnt_q != 8'hFF)) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end else begin
            waitCnt_d = waitCnt_q;
        end
    end

    // Moore outputs. They are forced low while rst_n is asserted, so the
    // FETCH read strobe cannot show during reset. In FETCH, the PC and IR
    // loads wait for the fetched word.
    always_comb begin
        pcwrite_o     = 1'b0;
        pcwritecond_o = 1'b0;
        iord_o        = 1'b0;
        memread_o     = 1'b0;
        memwrite_o    = 1'b0;
        irwrite_o     = 1'b0;
        memtoreg_o    = 1'b0;
        regdst_o      = 1'b0;
        regwrite_o    = 1'b0;
        alusrca_o     = 1'b0;
        alusrcb_o     = 2'b00;
        aluop_o       = 2'b00;
        pcsource_o    = 2'b00;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    memread_o = 1'b1;
                    alusrcb_o = 2'b01;
                    irwrite_o = mem_ready_i;
                    pcwrite_o = mem_ready_i;
                end
                DECODE: begin
                    alusrcb_o = 2'b11;
                end
                MEMADR, ADDIEX: begin
                    alusrca_o = 1'b1;
                    alusrcb_o = 2'b10;
                end
                MEMRD: begin
                    memread_o = 1'b1;
                    iord_o    = 1'b1;
                end
                MEMWB: begin
                    regwrite_o = 1'b1;
                    memtoreg_o = 1'b1;
                end
                MEMWR: begin
                    memwrite_o = 1'b1;
                    iord_o     = 1'b1;
                end
                EXEC: begin
                    alusrca_o = 1'b1;
                    aluop_o   = 2'b10;
                end
                ALUWB: begin
                    regwrite_o = 1'b1;
                    regdst_o   = 1'b1;
                end
                BRANCH: begin
                    alusrca_o     = 1'b1;
                    aluop_o       = 2'b01;
                    pcwritecond_o = 1'b1;
                    pcsource_o    = 2'b01;
                end
                JUMP: begin
                    pcwrite_o  = 1'b1;
                    pcsource_o = 2'b10;
                end
                ADDIWB: begin
                    regwrite_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal_o = illegal_q;
    assign state_o   = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] instrCount_q;
    logic             retire;

    // Retirement is the normal completion edge back into FETCH. Illegal and
    // timeout returns are deliberately excluded.
    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH)
                    || (state_q == JUMP) || (state_q == ADDIWB)
                    || ((state_q == MEMWR) && mem_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrCount_q <= '0;
        end else if (retire) begin
            instrCount_q <= instrCount_q + CNT_W'(1);
        end
    end

    assign instr_count_o = instrCount_q;
`else
    assign instr_count_o = '0;
`endif

endmodule
